// File: rtl/ula_if.sv
// ula_if: operand/opcode request and result response bundle for ula_pipe
interface ula_if #(parameter int DATA_WIDTH = 8);
  logic                    valid_i;
  logic                    ready_o;
  logic [DATA_WIDTH-1:0]   data_i_1;
  logic [DATA_WIDTH-1:0]   data_i_2;
  logic [2:0]              sel_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [2*DATA_WIDTH-1:0] data_o;
  logic                    err_o;
  modport master (output valid_i, data_i_1, data_i_2, sel_i, ready_i,
                  input  ready_o, valid_o, data_o, err_o);
  modport slave  (input  valid_i, data_i_1, data_i_2, sel_i, ready_i,
                  output ready_o, valid_o, data_o, err_o);
endinterface

// File: rtl/ula_pipe.sv
// ula_pipe: single-issue ALU with valid/ready handshakes; define ULA_MUL_EN to build
// the shift-add multiplier for opcode 111 (otherwise 111 returns err_o=1).
module ula_pipe #(parameter int DATA_WIDTH = 8) (
  input logic clk,
  input logic rst,
  ula_if.slave u
);
  localparam int W2 = 2 * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, HOLD} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [2:0] sel_q;
  logic [W2-1:0] za, zb, res, data_q, mul_res;
  logic err_q, valid_q, accept, is_mul, mul_done, res_err;
  assign accept    = u.valid_i & u.ready_o;
  assign u.ready_o = (state == IDLE) & ~rst;
  assign u.valid_o = valid_q;
  assign u.data_o  = data_q;
  assign u.err_o   = err_q;
  assign za = {{DATA_WIDTH{1'b0}}, a_q};
  assign zb = {{DATA_WIDTH{1'b0}}, b_q};
  assign res = sel_q == 3'd0 ? za + zb :
               sel_q == 3'd1 ? za - zb :
               sel_q == 3'd2 ? za + W2'(1) :
               sel_q == 3'd3 ? za - W2'(1) :
               sel_q == 3'd4 ? za & zb :
               sel_q == 3'd5 ? za | zb :
               sel_q == 3'd6 ? za ^ zb : '0;
`ifdef ULA_MUL_EN
  localparam logic [DATA_WIDTH-1:0] LAST = DATA_WIDTH'(DATA_WIDTH - 1);
  logic [W2-1:0] ma, acc;
  logic [DATA_WIDTH-1:0] mb, cnt;
  assign is_mul   = u.sel_i == 3'b111;
  assign res_err  = 1'b0;
  // the final partial product is folded in on the same edge that loads data_o
  assign mul_res  = acc + (mb[0] ? ma : '0);
  assign mul_done = cnt == LAST;
  always_ff @(posedge clk)
    if (rst) begin
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      ma  <= {{DATA_WIDTH{1'b0}}, u.data_i_1};
      mb  <= u.data_i_2;
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL) begin
      acc <= mul_res;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + DATA_WIDTH'(1);
    end
`else
  assign is_mul   = 1'b0;
  assign res_err  = sel_q == 3'b111;
  assign mul_res  = '0;
  assign mul_done = 1'b1;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = is_mul ? MUL : EXEC;
    else if (state == EXEC || (state == MUL && mul_done)) state_n = HOLD;
    else if (state == HOLD && u.ready_i) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= u.data_i_1;
        b_q   <= u.data_i_2;
        sel_q <= u.sel_i;
      end
      if (state == EXEC) begin
        data_q  <= res;
        err_q   <= res_err;
        valid_q <= 1'b1;
      end else if (state == MUL && mul_done) begin
        data_q  <= mul_res;
        err_q   <= 1'b0;
        valid_q <= 1'b1;
      end else if (state == HOLD && u.ready_i) valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_ula_pipe.sv
// tb_ula_pipe: directed-vector bench for ula_pipe (DATA_WIDTH=8), either ULA_MUL_EN setting
module tb_ula_pipe;
  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  ula_if #(.DATA_WIDTH(8)) bus();
  ula_pipe #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .u(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_d, input logic exp_e,
                        input int lat);
    bus.valid_i = 1'b1;
    bus.sel_i = sel;
    bus.data_i_1 = a;
    bus.data_i_2 = b;
    bus.ready_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    chk({tag, " ready_o busy"}, 32'(bus.ready_o), 32'd0);
    repeat (lat - 2) step();
    chk({tag, " valid_o early"}, 32'(bus.valid_o), 32'd0);
    step();
    chk({tag, " valid_o"}, 32'(bus.valid_o), 32'd1);
    chk({tag, " data_o"}, 32'(bus.data_o), 32'(exp_d));
    chk({tag, " err_o"}, 32'(bus.err_o), 32'(exp_e));
    step();
    chk({tag, " valid_o fall"}, 32'(bus.valid_o), 32'd0);
    chk({tag, " ready_o back"}, 32'(bus.ready_o), 32'd1);
    chk({tag, " data_o kept"}, 32'(bus.data_o), 32'(exp_d));
  endtask
  initial begin
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.sel_i = 3'd0;
    bus.data_i_1 = 8'h00;
    bus.data_i_2 = 8'h00;
    step();
    step();
    chk("rst ready_o", 32'(bus.ready_o), 32'd0);
    chk("rst valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst data_o", 32'(bus.data_o), 32'h0000);
    chk("rst err_o", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst ready_o", 32'(bus.ready_o), 32'd1);
    run_op("add", 3'b000, 8'hFF, 8'hFF, 16'h01FE, 1'b0, 2);
    run_op("sub", 3'b001, 8'h03, 8'h05, 16'hFFFE, 1'b0, 2);
    run_op("dec", 3'b011, 8'h00, 8'h00, 16'hFFFF, 1'b0, 2);
    run_op("xor", 3'b110, 8'hF0, 8'hFF, 16'h000F, 1'b0, 2);
    run_op("and", 3'b100, 8'hF0, 8'h3C, 16'h0030, 1'b0, 2);
    run_op("or", 3'b101, 8'h0F, 8'hF0, 16'h00FF, 1'b0, 2);
    // backpressure: result must hold while a new request is presented and ignored
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.sel_i = 3'b010;
    bus.data_i_1 = 8'hFF;
    bus.data_i_2 = 8'h00;
    step();
    bus.sel_i = 3'b000;
    bus.data_i_1 = 8'h01;
    bus.data_i_2 = 8'h01;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp valid_o", 32'(bus.valid_o), 32'd1);
      chk("bp data_o", 32'(bus.data_o), 32'h0100);
      chk("bp ready_o", 32'(bus.ready_o), 32'd0);
      if (i < 4) step();
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    step();
    chk("bp handshake valid_o", 32'(bus.valid_o), 32'd0);
    chk("bp handshake ready_o", 32'(bus.ready_o), 32'd1);
    step();
    step();
    chk("bp no queued op", 32'(bus.valid_o), 32'd0);
    chk("bp data kept", 32'(bus.data_o), 32'h0100);
`ifdef ULA_MUL_EN
    run_op("mul", 3'b111, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9);
    run_op("mul small", 3'b111, 8'h12, 8'h34, 16'h03A8, 1'b0, 9);
`else
    run_op("mul off", 3'b111, 8'hFF, 8'hFF, 16'h0000, 1'b1, 2);
`endif
    // reset in the middle of an operation aborts it
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.sel_i = 3'b111;
    bus.data_i_1 = 8'h12;
    bus.data_i_2 = 8'h34;
    step();
    bus.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef ULA_MUL_EN
      chk("abort valid_o pre-rst", 32'(bus.valid_o), 32'd0);
`endif
      step();
    end
    rst = 1'b1;
    step();
    step();
    chk("abort valid_o", 32'(bus.valid_o), 32'd0);
    chk("abort data_o", 32'(bus.data_o), 32'h0000);
    chk("abort err_o", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    step();
    chk("abort stays quiet", 32'(bus.valid_o), 32'd0);
    run_op("add after rst", 3'b000, 8'h01, 8'h02, 16'h0003, 1'b0, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ula_pipe.md
ULA_PIPE -- requirements
Module: ula_pipe

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand width in bits; legal values >= 2.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 valid_i  input  1  operands and opcode on data_i_1, data_i_2, sel_i are valid.
REQ-005 ready_o  output  1  block can accept an operation this cycle.
REQ-006 data_i_1  input  DATA_WIDTH  operand A, unsigned.
REQ-007 data_i_2  input  DATA_WIDTH  operand B, unsigned.
REQ-008 sel_i  input  3  opcode.
REQ-009 valid_o  output  1  data_o and err_o hold a result.
REQ-010 ready_i  input  1  downstream accepts the result this cycle.
REQ-011 data_o  output  2*DATA_WIDTH  result.
REQ-012 err_o  output  1  result is for an unsupported opcode.

Function
REQ-013 States SHALL be IDLE, EXEC, MUL, HOLD; ready_o SHALL be 1 only in IDLE with rst low.
REQ-014 Accept = valid_i & ready_o; operands and opcode SHALL be registered on accept; inputs SHALL be ignored otherwise.
REQ-015 IDLE: on accept with sel_i=111 and ULA_MUL_EN defined -> MUL; on any other accept -> EXEC; else stay.
REQ-016 EXEC: data_o, err_o SHALL load and valid_o SHALL rise on the next edge; state -> HOLD (valid_o high 2 edges after accept).
REQ-017 MUL: shift-add, one partial product per cycle, DATA_WIDTH-bit counter; after DATA_WIDTH steps data_o SHALL load the product and valid_o SHALL rise (DATA_WIDTH+1 edges after accept); -> HOLD.
REQ-018 HOLD: data_o, err_o, valid_o SHALL stay stable while ready_i=0; with ready_i=1, valid_o SHALL fall on that edge; -> IDLE.
REQ-019 Next accept SHALL be no earlier than the cycle after handshake; no overlap of operations.
REQ-020 Opcodes (operands zero-extended to 2*DATA_WIDTH, arithmetic modulo 2^(2*DATA_WIDTH)): 000 A+B; 001 A-B; 010 A+1; 011 A-1; 100 A&B; 101 A|B; 110 A^B; 111 A*B unsigned full product.
REQ-021 Boundaries (DATA_WIDTH=8): 0xFF+0xFF=0x01FE; 0x03-0x05=0xFFFE; 0xFF+1=0x0100; 0x00-1=0xFFFF; 0xFF*0xFF=0xFE01.
REQ-022 Logical ops SHALL drive upper DATA_WIDTH bits of data_o to zero.
REQ-023 err_o SHALL be 0 for every opcode except as in REQ-029.
REQ-024 valid_i held high while ready_o=0 SHALL NOT queue or drop-in-flight an operation; only the accepted one completes.
REQ-025 data_o SHALL retain its last value after valid_o falls until the next result loads.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, valid_o=0, data_o=0, err_o=0, multiplier counter and accumulator=0.
REQ-027 ready_o SHALL be 0 while rst=1 and 1 on the first cycle after rst falls.
REQ-028 rst during EXEC, MUL or HOLD SHALL abort the operation; no result SHALL be presented for it.

Configuration
REQ-029 Macro ULA_MUL_EN: defined -> MUL state and multiplier built, opcode 111 per REQ-017; undefined -> no multiplier logic, opcode 111 takes EXEC path with data_o=0, err_o=1, latency 2.

Verification
REQ-030 Reset then idle: rst 2 cycles -> valid_o=0, data_o=0x0000, err_o=0, ready_o=1 cycle after release.
REQ-031 ADD A=0xFF B=0xFF sel=000, ready_i=1 -> valid_o one cycle, 2 edges after accept, data_o=0x01FE; ready_o back at 1 next cycle.
REQ-032 SUB A=0x03 B=0x05 and DEC A=0x00 -> 0xFFFE and 0xFFFF; XOR A=0xF0 B=0xFF -> 0x000F.
REQ-033 Backpressure: INC A=0xFF, ready_i=0 for 5 cycles -> valid_o, data_o=0x0100 stable 5 cycles, ready_o=0, new valid_i ignored; ready_i=1 -> handshake, IDLE.
REQ-034 MUL A=0xFF B=0xFF: ULA_MUL_EN defined -> data_o=0xFE01 9 edges after accept, err_o=0; undefined -> data_o=0x0000, err_o=1 2 edges after accept.
REQ-035 Reset mid-MUL: assert rst 4 cycles after accept of 0x12*0x34 -> valid_o never rises for it, data_o=0, next ADD 0x01+0x02 returns 0x0003.
